// File: rtl/ds18b20_pkg.sv
// Shared encodings for the DS18B20 measurement sequencer: engine opcodes,
// ROM/function command bytes, the sequencer state set and per-state command lookup.
package ds18b20_pkg;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam logic [7:0] SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CONVERT_T    = 8'h44;
    localparam logic [7:0] READ_SCRATCH = 8'hBE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST1,
        ST_SKIP1,
        ST_CONV,
        ST_WAIT,
        ST_RST2,
        ST_SKIP2,
        ST_RDSP,
        ST_RDL,
        ST_RDM,
        ST_DONE
    } state_t;

    // States that issue exactly one engine command and wait for its response.
    function automatic logic is_cmd_state(input state_t s);
        return s inside {ST_RST1, ST_SKIP1, ST_CONV, ST_RST2,
                         ST_SKIP2, ST_RDSP, ST_RDL, ST_RDM};
    endfunction

    function automatic logic [1:0] state_op(input state_t s);
        case (s)
            ST_SKIP1, ST_CONV, ST_SKIP2, ST_RDSP: return OP_WRITE;
            ST_RDL, ST_RDM:                       return OP_READ;
            default:                              return OP_RESET;
        endcase
    endfunction

    function automatic logic [7:0] state_data(input state_t s);
        case (s)
            ST_SKIP1, ST_SKIP2: return SKIP_ROM;
            ST_CONV:            return CONVERT_T;
            ST_RDSP:            return READ_SCRATCH;
            default:            return 8'h00;
        endcase
    endfunction

    // Successor after a command state's response has been consumed.
    function automatic state_t next_state(input state_t s);
        case (s)
            ST_RST1:  return ST_SKIP1;
            ST_SKIP1: return ST_CONV;
            ST_CONV:  return ST_WAIT;
            ST_RST2:  return ST_SKIP2;
            ST_SKIP2: return ST_RDSP;
            ST_RDSP:  return ST_RDL;
            ST_RDL:   return ST_RDM;
            ST_RDM:   return ST_DONE;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ds18b20_tick.sv
// Millisecond prescaler: one-cycle tick every TICK_CYCLES clocks; restart holds
// the count at zero so the first tick lands TICK_CYCLES cycles after release.
module ds18b20_tick #(
    parameter int TICK_CYCLES = 50000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_reg;
    logic          tick_reg;

    always_ff @(posedge clk_in) begin
        if (rst || restart) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == LAST) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/ds18b20_seq.sv
// DS18B20 measurement sequencer: reset/skip/convert, timed wait, reset/skip/read
// scratchpad, two byte reads; publishes the temperature on demand or periodically.
module ds18b20_seq
    import ds18b20_pkg::*;
#(
    parameter int TICK_CYCLES  = 50000,
    parameter int CONV_TICKS   = 750,
    parameter int PERIOD_TICKS = 1000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    output logic        cmd_valid,
    output logic [1:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_presence,
    output logic        busy,
    output logic [15:0] temp_raw,
    output logic [7:0]  temp_c,
    output logic        temp_valid,
    output logic        err_no_presence
);

    localparam int WAIT_W = (CONV_TICKS > 1) ? $clog2(CONV_TICKS) : 1;
    localparam int PRD_W  = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
    localparam logic [WAIT_W-1:0] CONV_LAST   = WAIT_W'(CONV_TICKS - 1);
    localparam logic [PRD_W-1:0]  PERIOD_LAST = PRD_W'(PERIOD_TICKS - 1);

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [PRD_W-1:0]  prd_cnt_reg;
    logic              pending_reg;
    logic [7:0]        lsb_reg;
    logic              cmd_valid_reg;
    logic [1:0]        cmd_op_reg;
    logic [7:0]        cmd_data_reg;
    logic              busy_reg;
    logic [15:0]       temp_raw_reg;
    logic [7:0]        temp_c_reg;
    logic              temp_valid_reg;
    logic              err_reg;

    logic   wait_tick;
    logic   prd_tick;
    logic   wait_restart;
    logic   prd_restart;
    logic   period_hit;
    logic   go;
    logic   rsp_take;
    logic   presence_fail;
    logic   wait_done;
    state_t adv_state;

    // The wait prescaler is held in restart outside WAIT, so it restarts on entry.
    assign wait_restart = (state_reg != ST_WAIT);
    assign prd_restart  = !auto_en;

    ds18b20_tick #(.TICK_CYCLES(TICK_CYCLES)) wait_timer (
        .clk_in  (clk_in),
        .rst     (rst),
        .restart (wait_restart),
        .tick    (wait_tick)
    );

    ds18b20_tick #(.TICK_CYCLES(TICK_CYCLES)) period_timer (
        .clk_in  (clk_in),
        .rst     (rst),
        .restart (prd_restart),
        .tick    (prd_tick)
    );

    always_ff @(posedge clk_in) begin
        if (rst || !auto_en) begin
            prd_cnt_reg <= '0;
        end else if (prd_tick) begin
            prd_cnt_reg <= (prd_cnt_reg == PERIOD_LAST) ? '0 : prd_cnt_reg + 1'b1;
        end
    end

    assign period_hit    = auto_en && prd_tick && (prd_cnt_reg == PERIOD_LAST);
    assign go            = (state_reg == ST_IDLE) && (start || pending_reg);
    // A response only counts once the command has been accepted.
    assign rsp_take      = is_cmd_state(state_reg) && !cmd_valid_reg && rsp_valid;
    assign presence_fail = rsp_take && (state_op(state_reg) == OP_RESET) && !rsp_presence;
    assign wait_done     = (state_reg == ST_WAIT) && wait_tick && (wait_cnt_reg == CONV_LAST);
    assign adv_state     = next_state(state_reg);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            pending_reg    <= 1'b0;
            lsb_reg        <= 8'h00;
            cmd_valid_reg  <= 1'b0;
            cmd_op_reg     <= OP_RESET;
            cmd_data_reg   <= 8'h00;
            busy_reg       <= 1'b0;
            temp_raw_reg   <= 16'h0000;
            temp_c_reg     <= 8'h00;
            temp_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            temp_valid_reg <= 1'b0;

            // Departure wins over a simultaneous period hit: one sequence only.
            if (go) begin
                pending_reg <= 1'b0;
            end else if (period_hit) begin
                pending_reg <= 1'b1;
            end

            if (state_reg == ST_WAIT) begin
                if (wait_tick) begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
            end else begin
                wait_cnt_reg <= '0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (go) begin
                        state_reg     <= ST_RST1;
                        busy_reg      <= 1'b1;
                        cmd_valid_reg <= 1'b1;
                        cmd_op_reg    <= state_op(ST_RST1);
                        cmd_data_reg  <= state_data(ST_RST1);
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        state_reg     <= ST_RST2;
                        cmd_valid_reg <= 1'b1;
                        cmd_op_reg    <= state_op(ST_RST2);
                        cmd_data_reg  <= state_data(ST_RST2);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    if (cmd_valid_reg && cmd_ready) begin
                        cmd_valid_reg <= 1'b0;
                    end
                    if (presence_fail) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (rsp_take) begin
                        if (state_op(state_reg) == OP_RESET) begin
                            err_reg <= 1'b0;
                        end
                        if (state_reg == ST_RDL) begin
                            lsb_reg <= rsp_data;
                        end
                        // MSB arrives last; the published value is valid during DONE.
                        if (state_reg == ST_RDM) begin
                            temp_raw_reg   <= {rsp_data, lsb_reg};
                            temp_c_reg     <= {rsp_data[3:0], lsb_reg[7:4]};
                            temp_valid_reg <= 1'b1;
                        end
                        state_reg <= adv_state;
                        if (is_cmd_state(adv_state)) begin
                            cmd_valid_reg <= 1'b1;
                            cmd_op_reg    <= state_op(adv_state);
                            cmd_data_reg  <= state_data(adv_state);
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_valid       = cmd_valid_reg;
    assign cmd_op          = cmd_op_reg;
    assign cmd_data        = cmd_data_reg;
    assign busy            = busy_reg;
    assign temp_raw        = temp_raw_reg;
    assign temp_c          = temp_c_reg;
    assign temp_valid      = temp_valid_reg;
    assign err_no_presence = err_reg;

endmodule

// File: tb/tb_ds18b20_seq.sv
// Bench for ds18b20_seq: a behavioural byte engine feeds responses, expected
// commands and temperatures are queued by the stimulus and popped by monitors.
module tb_ds18b20_seq;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        start;
    logic        auto_en;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_presence;
    logic        busy;
    logic [15:0] temp_raw;
    logic [7:0]  temp_c;
    logic        temp_valid;
    logic        err_no_presence;

    always #5 clk_in = ~clk_in;

    ds18b20_seq #(.TICK_CYCLES(10), .CONV_TICKS(3), .PERIOD_TICKS(4)) dut (
        .clk_in          (clk_in),
        .rst             (rst),
        .start           (start),
        .auto_en         (auto_en),
        .cmd_valid       (cmd_valid),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .cmd_ready       (cmd_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_presence    (rsp_presence),
        .busy            (busy),
        .temp_raw        (temp_raw),
        .temp_c          (temp_c),
        .temp_valid      (temp_valid),
        .err_no_presence (err_no_presence)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0]  exp_cmd[$];
    logic [23:0] exp_temp[$];
    logic [7:0]  rd_bytes[$];

    int   rdy_delay = 0;
    int   rsp_delay = 2;
    logic presence  = 1'b1;
    int   cyc = 0;
    int   acc_count = 0;
    int   conv_rsp_cyc = -1;
    int   starts = 0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc_wait(1);
        start = 1'b0;
    endtask

    task automatic push_seq(input logic [15:0] raw, input logic [7:0] c);
        exp_cmd.push_back({2'd0, 8'h00});
        exp_cmd.push_back({2'd1, 8'hCC});
        exp_cmd.push_back({2'd1, 8'h44});
        exp_cmd.push_back({2'd0, 8'h00});
        exp_cmd.push_back({2'd1, 8'hCC});
        exp_cmd.push_back({2'd1, 8'hBE});
        exp_cmd.push_back({2'd2, 8'h00});
        exp_cmd.push_back({2'd2, 8'h00});
        rd_bytes.push_back(raw[7:0]);
        rd_bytes.push_back(raw[15:8]);
        exp_temp.push_back({raw, c});
    endtask

    task automatic wait_busy(input logic v, input int max, input string name);
        int k = 0;
        while (busy !== v && k < max) begin
            cyc_wait(1);
            k++;
        end
        check16(name, {15'h0, busy}, {15'h0, v});
    endtask

    task automatic wait_acc(input int target, input int max, input string name);
        int k = 0;
        while (acc_count < target && k < max) begin
            cyc_wait(1);
            k++;
        end
        check16(name, 16'(acc_count), 16'(target));
    endtask

    task automatic check_queues(input string name);
        check16({name, "_cmds_left"}, 16'(exp_cmd.size()), 16'h0);
        check16({name, "_temps_left"}, 16'(exp_temp.size()), 16'h0);
    endtask

    task automatic check_reset_vals(input string name);
        check16({name, "_cmd"}, {5'h0, cmd_valid, cmd_op, cmd_data}, 16'h0);
        check16({name, "_busy"}, {15'h0, busy}, 16'h0);
        check16({name, "_raw"}, temp_raw, 16'h0);
        check16({name, "_c"}, {8'h0, temp_c}, 16'h0);
        check16({name, "_tv"}, {15'h0, temp_valid}, 16'h0);
        check16({name, "_err"}, {15'h0, err_no_presence}, 16'h0);
    endtask

    task automatic do_reset();
        exp_cmd.delete();
        exp_temp.delete();
        rd_bytes.delete();
        conv_rsp_cyc = -1;
        rst = 1'b1;
        cyc_wait(1);
        rst = 1'b0;
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Behavioural byte engine; also checks handshake rules and the command order.
    initial begin : engine
        int e_state;
        int cnt;
        logic [1:0] cur_op;
        logic [7:0] cur_data;
        logic [9:0] e;
        e_state = 0;
        cnt = 0;
        cur_op = 2'd0;
        cur_data = 8'h00;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = 8'h00;
        rsp_presence = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (e_state == 4) begin
                rsp_valid = 1'b0;
                if (cur_op == 2'd1 && cur_data == 8'h44) conv_rsp_cyc = cyc;
                e_state = 0;
            end else if (e_state == 3) begin
                check16("no_cmd_before_rsp", {15'h0, cmd_valid}, 16'h0);
                if (cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_presence = presence;
                    rsp_data = (cur_op == 2'd2 && rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'h00;
                    e_state = 4;
                end else begin
                    cnt--;
                end
            end else if (e_state == 2) begin
                cmd_ready = 1'b0;
                acc_count++;
                check16("valid_drop_after_accept", {15'h0, cmd_valid}, 16'h0);
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: got op %0d data %h expected none", cur_op, cur_data);
                end else begin
                    e = exp_cmd.pop_front();
                    check16("cmd_order", {6'h0, cur_op, cur_data}, {6'h0, e});
                end
                $display("cycle %0d: accepted op=%0d data=%h", cyc, cur_op, cur_data);
                cnt = rsp_delay;
                e_state = 3;
            end else if (e_state == 1) begin
                check16("cmd_hold", {5'h0, cmd_valid, cmd_op, cmd_data}, {5'h0, 1'b1, cur_op, cur_data});
                cnt--;
                if (cnt == 0) begin
                    cmd_ready = 1'b1;
                    e_state = 2;
                end
            end
            if (e_state == 0 && cmd_valid === 1'b1) begin
                cur_op = cmd_op;
                cur_data = cmd_data;
                if (cur_op == 2'd0 && conv_rsp_cyc >= 0) begin
                    check16("conv_wait_min", {15'h0, (cyc - conv_rsp_cyc) > 30}, 16'h1);
                    check16("conv_wait_max", {15'h0, (cyc - conv_rsp_cyc) <= 40}, 16'h1);
                    conv_rsp_cyc = -1;
                end
                if (rdy_delay == 0) begin
                    cmd_ready = 1'b1;
                    e_state = 2;
                end else begin
                    cnt = rdy_delay;
                    e_state = 1;
                end
            end
        end
    end

    // Temperature monitor: pops the expected reading on every temp_valid pulse.
    initial begin : temp_mon
        logic [23:0] t;
        forever begin
            @(posedge clk_in);
            #1;
            if (temp_valid === 1'b1) begin
                $display("cycle %0d: temp_raw=%h temp_c=%h", cyc, temp_raw, temp_c);
                if (exp_temp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL temp_unexpected: got %h expected none", temp_raw);
                end else begin
                    t = exp_temp.pop_front();
                    check16("temp_raw", temp_raw, t[23:8]);
                    check16("temp_c", {8'h0, temp_c}, {8'h0, t[7:0]});
                end
                @(posedge clk_in);
                #1;
                check16("temp_valid_width", {15'h0, temp_valid}, 16'h0);
                check16("busy_after_done", {15'h0, busy}, 16'h0);
            end
        end
    end

    initial begin : start_mon
        logic busy_d;
        busy_d = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (busy === 1'b1 && busy_d === 1'b0) starts++;
            busy_d = busy;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000ns");
        $fatal(1);
    end

    initial begin : stim
        int s0;
        rst = 1'b1;
        start = 1'b0;
        auto_en = 1'b0;
        cyc_wait(3);
        rst = 1'b0;
        check_reset_vals("reset");
        cyc_wait(2);

        // Nominal measurement, 0x0191 -> 25 degC
        push_seq(16'h0191, 8'd25);
        pulse_start();
        wait_busy(1'b0, 300, "nominal_done");
        cyc_wait(3);
        check16("nominal_err", {15'h0, err_no_presence}, 16'h0);
        check_queues("nominal");

        // Negative temperature rounds toward minus infinity
        push_seq(16'hFF5E, 8'hF5);
        pulse_start();
        wait_busy(1'b0, 300, "negative_done");
        cyc_wait(3);
        check_queues("negative");

        // Missing presence stops after the first reset
        presence = 1'b0;
        exp_cmd.push_back({2'd0, 8'h00});
        pulse_start();
        wait_busy(1'b0, 100, "nopres_done");
        check16("nopres_err", {15'h0, err_no_presence}, 16'h1);
        check16("nopres_raw_kept", temp_raw, 16'hFF5E);
        check16("nopres_c_kept", {8'h0, temp_c}, 16'h00F5);
        cyc_wait(20);
        check16("nopres_busy", {15'h0, busy}, 16'h0);
        check_queues("nopres");
        presence = 1'b1;
        push_seq(16'h0191, 8'd25);
        pulse_start();
        wait_busy(1'b0, 300, "pres_again_done");
        cyc_wait(3);
        check16("pres_again_err", {15'h0, err_no_presence}, 16'h0);
        check_queues("pres_again");

        // Slow cmd_ready and start pulses while busy
        rdy_delay = 5;
        s0 = starts;
        push_seq(16'h0550, 8'h55);
        pulse_start();
        cyc_wait(3);
        pulse_start();
        cyc_wait(40);
        pulse_start();
        wait_busy(1'b0, 500, "handshake_done");
        cyc_wait(20);
        check16("handshake_single_seq", 16'(starts - s0), 16'd1);
        check_queues("handshake");
        rdy_delay = 0;

        // Periodic mode: one hit while busy queues exactly one more sequence
        rsp_delay = 10;
        s0 = starts;
        push_seq(16'h0191, 8'd25);
        push_seq(16'hFF5E, 8'hF5);
        auto_en = 1'b1;
        wait_busy(1'b1, 80, "auto_first_start");
        cyc_wait(60);
        auto_en = 1'b0;
        wait_busy(1'b0, 400, "auto_a_done");
        cyc_wait(2);
        check16("auto_queued_start", {15'h0, busy}, 16'h1);
        wait_busy(1'b0, 400, "auto_b_done");
        cyc_wait(100);
        check16("auto_seq_count", 16'(starts - s0), 16'd2);
        check_queues("auto");

        // Reset during the conversion wait
        rsp_delay = 2;
        push_seq(16'h0191, 8'd25);
        s0 = acc_count;
        pulse_start();
        wait_acc(s0 + 3, 100, "reach_conv");
        cyc_wait(10);
        do_reset();
        check_reset_vals("rst_wait");
        cyc_wait(50);
        check16("rst_wait_idle", {14'h0, busy, cmd_valid}, 16'h0);

        // Reset while the MSB read is outstanding; its late response is ignored
        rsp_delay = 6;
        push_seq(16'h0191, 8'd25);
        s0 = acc_count;
        pulse_start();
        wait_acc(s0 + 8, 400, "reach_rdm");
        do_reset();
        check_reset_vals("rst_rdm");
        cyc_wait(20);
        check16("rst_rdm_idle", {14'h0, busy, cmd_valid}, 16'h0);
        check16("rst_rdm_raw", temp_raw, 16'h0);

        rsp_delay = 2;
        push_seq(16'h0191, 8'd25);
        pulse_start();
        wait_busy(1'b0, 300, "after_rst_done");
        cyc_wait(3);
        check16("after_rst_raw", temp_raw, 16'h0191);
        check_queues("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
